// File: rtl/axil_master_if.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI-Lite
// read or write. A response timeout aborts the wait, and the late beat is drained afterwards.
module axil_master_if #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 4,
    parameter int P_TIMEOUT    = 256
) (
    input  logic                      m_axi_aclk,
    input  logic                      m_axi_aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [P_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [P_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_timeout,
    output logic [P_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [P_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [P_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [P_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [P_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int C_STRB_W = P_DATA_WIDTH / 8;
    localparam int C_CNT_W  = $clog2(P_TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(P_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RESP    = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    state_t                    state_r, state_s;
    logic [C_CNT_W-1:0]        cnt_r, cnt_s;
    logic                      stale_wr_r, stale_wr_s, stale_rd_r, stale_rd_s;
    logic                      cmd_ready_r, cmd_ready_s;
    logic [P_ADDR_WIDTH-1:0]   awaddr_r, awaddr_s, araddr_r, araddr_s;
    logic [P_DATA_WIDTH-1:0]   wdata_r, wdata_s, rsp_rdata_r, rsp_rdata_s;
    logic [C_STRB_W-1:0]       wstrb_r, wstrb_s;
    logic                      awvalid_r, awvalid_s, wvalid_r, wvalid_s;
    logic                      bready_r, bready_s, arvalid_r, arvalid_s, rready_r, rready_s;
    logic                      rsp_valid_r, rsp_valid_s, rsp_timeout_r, rsp_timeout_s;
    logic [1:0]                rsp_resp_r, rsp_resp_s;

    assign cmd_ready     = cmd_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
    assign rsp_timeout   = rsp_timeout_r;
    assign m_axi_awaddr  = awaddr_r;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_r;
    assign m_axi_wdata   = wdata_r;
    assign m_axi_wstrb   = wstrb_r;
    assign m_axi_wvalid  = wvalid_r;
    assign m_axi_bready  = bready_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        stale_wr_s    = stale_wr_r;
        stale_rd_s    = stale_rd_r;
        awaddr_s      = awaddr_r;
        araddr_s      = araddr_r;
        wdata_s       = wdata_r;
        wstrb_s       = wstrb_r;
        awvalid_s     = awvalid_r;
        wvalid_s      = wvalid_r;
        bready_s      = bready_r;
        arvalid_s     = arvalid_r;
        rready_s      = rready_r;
        rsp_valid_s   = rsp_valid_r;
        rsp_rdata_s   = rsp_rdata_r;
        rsp_resp_s    = rsp_resp_r;
        rsp_timeout_s = rsp_timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    if (cmd_write) begin
                        awaddr_s  = cmd_addr;
                        wdata_s   = cmd_wdata;
                        wstrb_s   = cmd_wstrb;
                        awvalid_s = 1'b1;
                        wvalid_s  = 1'b1;
                        state_s   = ST_WR_REQ;
                    end else begin
                        araddr_s  = cmd_addr;
                        arvalid_s = 1'b1;
                        state_s   = ST_RD_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; a valid only drops after its own handshake.
                if (awvalid_r && m_axi_awready) awvalid_s = 1'b0;
                else                            awvalid_s = awvalid_r;
                if (wvalid_r && m_axi_wready) wvalid_s = 1'b0;
                else                          wvalid_s = wvalid_r;
                if (!awvalid_s && !wvalid_s) begin
                    bready_s = 1'b1;
                    cnt_s    = {C_CNT_W{1'b0}};
                    state_s  = ST_WR_RESP;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_RD_REQ: begin
                if (arvalid_r && m_axi_arready) begin
                    arvalid_s = 1'b0;
                    rready_s  = 1'b1;
                    cnt_s     = {C_CNT_W{1'b0}};
                    state_s   = ST_RD_RESP;
                end else begin
                    state_s = ST_RD_REQ;
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid && bready_r) begin
                    rsp_resp_s  = m_axi_bresp;
                    rsp_rdata_s = {P_DATA_WIDTH{1'b0}};
                    bready_s    = 1'b0;
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else if (cnt_r == C_CNT_LAST) begin
                    rsp_resp_s    = 2'b10;
                    rsp_timeout_s = 1'b1;
                    rsp_rdata_s   = {P_DATA_WIDTH{1'b0}};
                    bready_s      = 1'b0;
                    stale_wr_s    = 1'b1;
                    rsp_valid_s   = 1'b1;
                    state_s       = ST_RESP;
                end else begin
                    cnt_s = cnt_r + C_CNT_W'(1);
                end
            end
            ST_RD_RESP: begin
                if (m_axi_rvalid && rready_r) begin
                    rsp_resp_s  = m_axi_rresp;
                    rsp_rdata_s = m_axi_rdata;
                    rready_s    = 1'b0;
                    rsp_valid_s = 1'b1;
                    state_s     = ST_RESP;
                end else if (cnt_r == C_CNT_LAST) begin
                    rsp_resp_s    = 2'b10;
                    rsp_timeout_s = 1'b1;
                    rsp_rdata_s   = {P_DATA_WIDTH{1'b0}};
                    rready_s      = 1'b0;
                    stale_rd_s    = 1'b1;
                    rsp_valid_s   = 1'b1;
                    state_s       = ST_RESP;
                end else begin
                    cnt_s = cnt_r + C_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    rsp_valid_s   = 1'b0;
                    rsp_timeout_s = 1'b0;
                    // An aborted transaction still owes us one beat; swallow it before going idle.
                    if (stale_wr_r) begin
                        bready_s = 1'b1;
                        state_s  = ST_DRAIN;
                    end else if (stale_rd_r) begin
                        rready_s = 1'b1;
                        state_s  = ST_DRAIN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (stale_wr_r && m_axi_bvalid && bready_r) begin
                    bready_s   = 1'b0;
                    stale_wr_s = 1'b0;
                    state_s    = ST_IDLE;
                end else if (stale_rd_r && m_axi_rvalid && rready_r) begin
                    rready_s   = 1'b0;
                    stale_rd_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        cmd_ready_s = (state_s == ST_IDLE) && !rsp_valid_s;
    end

    // State and registered-output update.
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {C_CNT_W{1'b0}};
            stale_wr_r    <= 1'b0;
            stale_rd_r    <= 1'b0;
            cmd_ready_r   <= 1'b0;
            awaddr_r      <= {P_ADDR_WIDTH{1'b0}};
            araddr_r      <= {P_ADDR_WIDTH{1'b0}};
            wdata_r       <= {P_DATA_WIDTH{1'b0}};
            wstrb_r       <= {C_STRB_W{1'b0}};
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            bready_r      <= 1'b0;
            arvalid_r     <= 1'b0;
            rready_r      <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {P_DATA_WIDTH{1'b0}};
            rsp_resp_r    <= 2'b00;
            rsp_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            stale_wr_r    <= stale_wr_s;
            stale_rd_r    <= stale_rd_s;
            cmd_ready_r   <= cmd_ready_s;
            awaddr_r      <= awaddr_s;
            araddr_r      <= araddr_s;
            wdata_r       <= wdata_s;
            wstrb_r       <= wstrb_s;
            awvalid_r     <= awvalid_s;
            wvalid_r      <= wvalid_s;
            bready_r      <= bready_s;
            arvalid_r     <= arvalid_s;
            rready_r      <= rready_s;
            rsp_valid_r   <= rsp_valid_s;
            rsp_rdata_r   <= rsp_rdata_s;
            rsp_resp_r    <= rsp_resp_s;
            rsp_timeout_r <= rsp_timeout_s;
        end
    end

endmodule

// File: tb/tb_axil_master_if.sv
// Bench for axil_master_if: a behavioural 4-register AXI-Lite slave with tunable
// latencies and a byte-strobed memory reference model.
module tb_axil_master_if;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axil_master_if #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(4), .P_TIMEOUT(16)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Slave configuration, written by the stimulus process.
    int         aw_delay, w_delay, b_delay, ar_delay, r_delay;
    bit         b_never, r_never;
    logic [1:0] b_resp_cfg, r_resp_cfg;

    logic [31:0] sreg [4];
    logic        aw_got, w_got, ar_got;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [3:0]  s_awaddr, s_araddr, s_wstrb;
    logic [31:0] s_wdata;

    // Behavioural AXI-Lite slave with programmable ready/response latencies.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; rresp <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            s_awaddr <= 4'h0; s_araddr <= 4'h0; s_wstrb <= 4'h0; s_wdata <= 32'h0;
            for (int i = 0; i < 4; i++) sreg[i] <= 32'h0;
        end else begin
            if (awvalid && awready) begin
                aw_got <= 1'b1; awready <= 1'b0; s_awaddr <= awaddr;
            end else if (awvalid && !aw_got && !awready) begin
                if (aw_wait >= aw_delay) awready <= 1'b1;
                else aw_wait <= aw_wait + 1;
            end
            if (wvalid && wready) begin
                w_got <= 1'b1; wready <= 1'b0; s_wdata <= wdata; s_wstrb <= wstrb;
            end else if (wvalid && !w_got && !wready) begin
                if (w_wait >= w_delay) wready <= 1'b1;
                else w_wait <= w_wait + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
                aw_wait <= 0; w_wait <= 0; b_wait <= 0;
            end else if (aw_got && w_got && !bvalid && !b_never) begin
                if (b_wait >= b_delay) begin
                    bvalid <= 1'b1; bresp <= b_resp_cfg;
                    for (int k = 0; k < 4; k++)
                        if (s_wstrb[k]) sreg[s_awaddr[3:2]][8*k +: 8] <= s_wdata[8*k +: 8];
                end else b_wait <= b_wait + 1;
            end
            if (arvalid && arready) begin
                ar_got <= 1'b1; arready <= 1'b0; s_araddr <= araddr;
            end else if (arvalid && !ar_got && !arready) begin
                if (ar_wait >= ar_delay) arready <= 1'b1;
                else ar_wait <= ar_wait + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0; ar_wait <= 0; r_wait <= 0;
            end else if (ar_got && !rvalid && !r_never) begin
                if (r_wait >= r_delay) begin
                    rvalid <= 1'b1; rresp <= r_resp_cfg; rdata <= sreg[s_araddr[3:2]];
                end else r_wait <= r_wait + 1;
            end
        end
    end

    int aw_hs = 0, w_hs = 0, b_hs = 0, cmd_hs = 0;
    // Handshake counters seen by the bench.
    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready)   w_hs  <= w_hs + 1;
        if (bvalid && bready)   b_hs  <= b_hs + 1;
        if (cmd_valid && cmd_ready) cmd_hs <= cmd_hs + 1;
    end

    // Reference model: a plain array of words with byte-strobe merging.
    logic [31:0] exp_mem [4];

    task automatic ref_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 4; k++)
            if (s[k]) exp_mem[a[3:2]][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic send_cmd(input logic w, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = $urandom; cmd_addr = $urandom;
        cmd_wdata = $urandom; cmd_wstrb = $urandom;
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] rd, output logic [1:0] rs,
                           output logic to);
        int n = 0;
        int bad = 0;
        while (!rsp_valid && n < 400) begin @(negedge clk); n++; end
        chk("rsp_valid_wait", rsp_valid, 1'b1);
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_rdata !== rd || rsp_resp !== rs || rsp_timeout !== to
                    || cmd_ready || awvalid || arvalid) bad++;
            end
            chk("rsp_hold_stable", bad, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
    endtask

    task automatic run_txn(input string tag, input logic w, input logic [3:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd, exp_rd;
        logic [1:0]  rs, exp_rs;
        logic        to;
        exp_rd = w ? 32'h0 : exp_mem[a[3:2]];
        exp_rs = w ? b_resp_cfg : r_resp_cfg;
        send_cmd(w, a, d, s);
        get_rsp(0, rd, rs, to);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_resp"}, rs, exp_rs);
        chk({tag, "_timeout"}, to, 1'b0);
        if (w) ref_write(a, d, s);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        to;
        int n, bad, seen, a0, w0, b0, h0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        b_never = 1'b0; r_never = 1'b0; b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;
        for (int i = 0; i < 4; i++) exp_mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready,
                           arvalid, rready, rsp_resp}, 10'h0);
        chk("reset_data", {|rsp_rdata, |wdata, |wstrb, |awaddr, |araddr}, 5'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'h0);
        chk("post_reset_cmd_ready", cmd_ready, 1'b1);

        // Directed write / read-back through the slave.
        run_txn("wr4", 1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
        chk("slave_reg1", sreg[1], 32'hDEADBEEF);
        run_txn("rd4", 1'b0, 4'h4, 32'h0, 4'h0);
        run_txn("wr8", 1'b1, 4'h8, 32'h12345678, 4'hF);
        run_txn("rd8", 1'b0, 4'h8, 32'h0, 4'h0);

        // Skewed AW/W readiness: W completes first, AW must keep waiting.
        aw_delay = 5; w_delay = 1;
        a0 = aw_hs; w0 = w_hs; b0 = b_hs; seen = 0; bad = 0; n = 0;
        send_cmd(1'b1, 4'h0, 32'hCAFE0001, 4'h3);
        while (!bready && n < 40) begin
            if (w_hs > w0 && aw_hs == a0) begin
                seen++;
                if (wvalid || !awvalid) bad++;
            end
            @(negedge clk); n++;
        end
        chk("skew_window_seen", seen > 0, 1'b1);
        chk("skew_valid_rules", bad, 0);
        get_rsp(0, rd, rs, to);
        chk("skew_resp", rs, 2'b00);
        ref_write(4'h0, 32'hCAFE0001, 4'h3);
        chk("skew_aw_once", aw_hs - a0, 1);
        chk("skew_w_once", w_hs - w0, 1);
        chk("skew_b_once", b_hs - b0, 1);
        aw_delay = 0; w_delay = 0;

        // Write timeout followed by a late B drained silently.
        b_never = 1'b1;
        send_cmd(1'b1, 4'hC, 32'h0BADF00D, 4'hF);
        n = 0;
        while (!bready && n < 40) begin @(negedge clk); n++; end
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        chk("tmo_latency", n, 16);
        get_rsp(0, rd, rs, to);
        chk("tmo_resp", rs, 2'b10);
        chk("tmo_flag", to, 1'b1);
        chk("tmo_rdata", rd, 32'h0);
        chk("tmo_flag_clear", rsp_timeout, 1'b0);
        chk("drain_bready", bready, 1'b1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (cmd_ready) bad++;
            @(negedge clk);
        end
        chk("drain_cmd_ready_low", bad, 0);
        b0 = b_hs; b_never = 1'b0; n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("drain_done", cmd_ready, 1'b1);
        chk("drain_one_b", b_hs - b0, 1);
        ref_write(4'hC, 32'h0BADF00D, 4'hF);

        // Held response with a second command already waiting.
        send_cmd(1'b0, 4'h0, 32'h0, 4'h0);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4;
        cmd_wdata = 32'hA5A5_5A5A; cmd_wstrb = 4'hC;
        h0 = cmd_hs;
        get_rsp(10, rd, rs, to);
        chk("hold_rdata", rd, exp_mem[0]);
        chk("b2b_not_early", cmd_hs, h0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_accepted", cmd_hs, h0 + 1);
        get_rsp(0, rd, rs, to);
        chk("b2b_resp", rs, 2'b00);
        ref_write(4'h4, 32'hA5A5_5A5A, 4'hC);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 24; t++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            b_resp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            r_resp_cfg = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            run_txn("rnd", 1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), 2'b00},
                    $urandom, 4'($urandom_range(0, 15)));
        end
        b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;

        // Asynchronous reset while waiting in the read response state.
        r_never = 1'b1;
        send_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        n = 0;
        while (!rready && n < 40) begin @(negedge clk); n++; end
        chk("rd_resp_reached", rready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {cmd_ready, rsp_valid, rsp_timeout, awvalid, wvalid, bready,
                               arvalid, rready, rsp_resp}, 10'h0);
        chk("async_rst_data", {|rsp_rdata, |wdata, |wstrb, |awaddr, |araddr}, 5'h0);
        for (int i = 0; i < 4; i++) exp_mem[i] = 32'h0;
        r_never = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'h0);
        chk("rerst_cmd_ready", cmd_ready, 1'b1);
        run_txn("post_wr", 1'b1, 4'h4, 32'h600DD00D, 4'hF);
        run_txn("post_rd", 1'b0, 4'h4, 32'h0, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_master_if.md
Name: axil_master_if

Overview:
Single-outstanding AXI4-Lite master. It converts a simple command/response interface into AXI4-Lite read and write transactions, and sits directly upstream of axil_slave_if. Fabric logic such as sequencers and test controllers uses it to access register banks over AXI-Lite. A response timeout protects the fabric from a slave that never answers.

Parameters:
P_DATA_WIDTH, 32, data width of the command and AXI data buses (multiple of 8)
P_ADDR_WIDTH, 4, byte address width (matches axil_slave_if default of 4 registers)
P_TIMEOUT, 256, cycles to wait in a response state before aborting (>=2)

Ports:
m_axi_aclk  in  1  clock
m_axi_aresetn  in  1  reset; asynchronous assert, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  block accepts a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  P_ADDR_WIDTH  byte address
cmd_wdata  in  P_DATA_WIDTH  write data
cmd_wstrb  in  P_DATA_WIDTH/8  write strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  P_DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  AXI response code, or 2'b10 on timeout
rsp_timeout  out  1  response was generated by timeout
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  P_ADDR_WIDTH/3/1/1  write address channel; awprot=3'b000
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  P_DATA_WIDTH/P_DATA_WIDTH/8/1/1  write data channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  P_ADDR_WIDTH/3/1/1  read address channel; arprot=3'b000
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  P_DATA_WIDTH/2/1/1  read data channel

Behaviour:
- Reset: every output and state register is 0 (state=IDLE, counter=0). Assertion is asynchronous; deassertion is sampled on a clock edge. No AXI valid is driven in the first cycle after reset.
- All outputs are registered. cmd_ready = (state==IDLE) & ~rsp_valid.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP, DRAIN.
- IDLE: on cmd_valid&cmd_ready, latch addr/wdata/wstrb. Next cycle: write -> WR_REQ with awvalid=wvalid=1; read -> RD_REQ with arvalid=1.
- WR_REQ: awvalid and wvalid are independent. Each drops the cycle after its own handshake and never drops before it. Both may complete in the same or different cycles. Once both have completed -> WR_RESP with bready=1.
- RD_REQ: arvalid held until arready -> RD_RESP with rready=1.
- Request-channel valids are never withdrawn; there is no timeout in WR_REQ or RD_REQ.
- WR_RESP/RD_RESP: counter clears on entry and increments each cycle without a handshake.
  - On bvalid&bready: rsp_resp<=bresp, rsp_rdata<=0, bready<=0 -> RESP.
  - On rvalid&rready: rsp_rdata<=rdata, rsp_resp<=rresp, rready<=0 -> RESP.
  - If the counter reaches P_TIMEOUT-1 without a handshake: rsp_resp<=2'b10, rsp_timeout<=1, rsp_rdata<=0, ready dropped, set stale flag (write or read) -> RESP.
  - A handshake in the expiry cycle wins over timeout.
- RESP: rsp_valid=1, outputs stable until rsp_ready.
  - On handshake: rsp_valid<=0, rsp_timeout<=0. Stale flag set -> DRAIN, else -> IDLE.
- DRAIN: re-assert bready or rready. Accept and discard exactly one late beat, then -> IDLE. No timeout; cmd_ready stays 0.
- Exactly one transaction is outstanding at any time. cmd_* inputs are ignored outside the IDLE handshake.

Test Plan:
- Write cmd addr=0x4, wdata=0xDEADBEEF, wstrb=0xF into axil_slave_if -> one AW and one W handshake, then B with OKAY; rsp_valid with rsp_resp=0, rsp_rdata=0; slave reg_1_data=0xDEADBEEF.
- Read back addr=0x4 -> rsp_rdata=0xDEADBEEF, rsp_resp=0. Read addr=0x8 with reg_2_data=0x12345678 -> rsp_rdata=0x12345678.
- Model slave with awready after 5 cycles and wready after 1 cycle -> wvalid drops after its handshake, awvalid stays high until cycle 5, exactly one B accepted.
- Model slave that never asserts bvalid, P_TIMEOUT=16 -> rsp_valid 16 cycles after WR_RESP entry with rsp_resp=2'b10, rsp_timeout=1. Then inject a late bvalid -> consumed in DRAIN; cmd_ready rises only afterwards.
- Hold rsp_ready=0 for 10 cycles -> rsp_* stable and cmd_ready=0 throughout. Send back-to-back commands -> second accepted only after the first response handshake.
- Assert reset mid-RD_RESP -> all outputs 0 immediately (asynchronously), state IDLE after release, and the next read completes normally.
